// File: rtl/uart_pkg.sv
// Shared constants, receiver state encoding and helpers for the UART receive path.
// Define UART_RX_PARITY_EN to add a parity bit between D7 and the stop bit.
package uart_pkg;

  localparam int OSR       = 16;
  localparam int OS_W      = $clog2(OSR);
  localparam int DATA_BITS = 8;
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam int DIV_W     = 16;

  localparam logic [OS_W-1:0]  SAMPLE_LO  = OS_W'(7);
  localparam logic [OS_W-1:0]  SAMPLE_MID = OS_W'(8);
  localparam logic [OS_W-1:0]  SAMPLE_HI  = OS_W'(9);
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OSR - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_BREAK  = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head on o_head_dat, a push is visible one clock later.
// A push while full with no same-cycle pop is dropped and flagged on o_drop.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   i_push_vld,
  input  logic [DW-1:0]          i_push_dat,
  input  logic                   i_pop_rdy,
  output logic [DW-1:0]          o_head_dat,
  output logic                   o_head_vld,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop   = i_pop_rdy & ~w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push  = i_push_vld & (~w_full | w_pop);
  assign o_drop  = i_push_vld & ~w_push;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_push_dat;
    end
  end

  assign o_head_dat = r_mem[r_rptr];
  assign o_head_vld = ~w_empty;
  assign o_level    = r_level;

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampled 8N1 receiver into a show-ahead FIFO; byte visible 1 clock after the stop decision.
// Consumer stalls with rx_ready_i=0; bytes arriving at a full FIFO are dropped (overrun_o). Macro: UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        serial_in_i,
  input  logic [DIV_W-1:0]            div_i,
  output logic [DATA_BITS-1:0]        rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic                        parity_err_o,
`ifdef UART_RX_PARITY_EN
  input  logic                        parity_odd_i,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  rx_state_e r_state;
  rx_state_e w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic                   w_rx;
  logic                   w_fall;

  logic [DIV_W-1:0]       r_div_cnt;
  logic [DIV_W-1:0]       r_div_lat;
  logic                   w_tick;

  logic [OS_W-1:0]        r_os_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic                   r_smp_lo;
  logic                   r_smp_mid;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   w_decide;
  logic                   w_maj;
  logic                   w_bit_end;

  logic                   w_clr_cnt;
  logic                   w_bit_clr;
  logic                   w_shift_en;
  logic                   w_push;
  logic                   w_frame_err;
  logic                   w_drop;
  logic                   r_frame_err;
  logic                   r_overrun;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], serial_in_i};
      r_rx_prev <= w_rx;
    end
  end

  assign w_rx   = r_sync[SYNC_STAGES-1];
  assign w_fall = r_rx_prev & ~w_rx;

  // The divisor is captured on each wrap so a change never truncates a tick period.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_div_cnt <= '0;
      r_div_lat <= '0;
    end else begin
      if (w_tick) r_div_lat <= div_i;
      if (w_clr_cnt || w_tick) r_div_cnt <= '0;
      else                     r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick    = (r_div_cnt == r_div_lat);
  assign w_decide  = w_tick & (r_os_cnt == SAMPLE_HI);
  assign w_bit_end = w_tick & (r_os_cnt == OS_LAST);
  assign w_maj     = maj3(r_smp_lo, r_smp_mid, w_rx);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_os_cnt  <= '0;
      r_smp_lo  <= 1'b1;
      r_smp_mid <= 1'b1;
    end else if (w_clr_cnt) begin
      r_os_cnt  <= '0;
    end else if (w_tick) begin
      r_os_cnt <= r_os_cnt + 1'b1;
      if (r_os_cnt == SAMPLE_LO)  r_smp_lo  <= w_rx;
      if (r_os_cnt == SAMPLE_MID) r_smp_mid <= w_rx;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic w_par_en;
  logic w_par_bad;
  logic w_parity_err;
  logic r_parity_err;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       r_par_bit <= 1'b0;
    else if (w_par_en) r_par_bit <= w_maj;
  end

  // Data plus parity bit has odd weight exactly when odd parity was sent.
  assign w_par_bad = ((^r_shift) ^ r_par_bit) != parity_odd_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_parity_err <= 1'b0;
    else         r_parity_err <= w_parity_err;
  end

  assign parity_err_o = r_parity_err;
`else
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_decide && w_maj) w_state_nxt = ST_IDLE;
        else if (w_bit_end)    w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_decide && (r_bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_decide) w_state_nxt = ST_STOP;
      end
`endif
      // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
      ST_STOP: begin
        if (w_decide) w_state_nxt = w_maj ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        if (w_rx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clr_cnt    = 1'b0;
    w_bit_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en     = 1'b0;
    w_parity_err = 1'b0;
`endif
    case (r_state)
      ST_IDLE:  w_clr_cnt  = w_fall;
      ST_START: w_bit_clr  = w_bit_end;
      ST_DATA:  w_shift_en = w_decide;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: w_par_en  = w_decide;
`endif
      ST_STOP: begin
        if (w_decide) begin
          if (!w_maj) w_frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (w_par_bad) w_parity_err = 1'b1;
`endif
          else w_push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_BITS)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .i_push_vld (w_push),
    .i_push_dat (r_shift),
    .i_pop_rdy  (rx_ready_i),
    .o_head_dat (rx_data_o),
    .o_head_vld (rx_valid_o),
    .o_level    (fifo_level_o),
    .o_drop     (w_drop)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_drop;
    end
  end

  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule
